// File: rtl/int_capture_5.sv
// Five-source interrupt capture block: synchronises raw sources, latches masked rising edges
// into pending flags, and runs a request/acknowledge handshake with the processor.
module int_capture_5 (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] src,
   input  logic       mask_wr,
   input  logic [4:0] mask_data,
   input  logic       clr_wr,
   input  logic [4:0] clr_data,
   input  logic       interrupt_ack,
   output logic       interrupt,
   output logic [4:0] pending,
   output logic [4:0] mask,
   output logic [2:0] active_id
);

   localparam int unsigned NSRC = 5;
   localparam int unsigned IDW  = 3;
   localparam logic [IDW-1:0] SPURIOUS_ID = IDW'(7);

   typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_t;

   state_t            state;
   logic [NSRC-1:0]   s1;
   logic [NSRC-1:0]   s2;
   logic [NSRC-1:0]   s3;
   logic [NSRC-1:0]   rise;
   logic [NSRC-1:0]   auto_clr;
   logic [NSRC-1:0]   clr_eff;
   logic [NSRC-1:0]   pending_next;
   logic [IDW-1:0]    low_id;
   logic              ack_take;

   // Edge detect, lowest-pending priority pick, and merged clear (set always wins)
   always_comb begin
      low_id = SPURIOUS_ID;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pending[i]) low_id = IDW'(i);
      end
      ack_take     = (state == REQ) && interrupt_ack;
      auto_clr     = ack_take ? NSRC'(pending & (~pending + NSRC'(1))) : '0;
      rise         = s2 & ~s3;
      clr_eff      = (clr_wr ? clr_data : '0) | auto_clr;
      pending_next = (pending & ~clr_eff) | (rise & mask);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         pending   <= '0;
         mask      <= '0;
         active_id <= '0;
         interrupt <= 1'b0;
         state     <= IDLE;
      end else begin
         s1      <= src;
         s2      <= s1;
         s3      <= s2;
         pending <= pending_next;
         if (mask_wr) mask <= mask_data;

         // Request handshake; REQ holds until acked even if pending drains
         case (state)
            IDLE: begin
               if (pending != '0) begin
                  state     <= REQ;
                  interrupt <= 1'b1;
               end
            end
            REQ: begin
               if (interrupt_ack) begin
                  active_id <= low_id;
                  interrupt <= 1'b0;
                  state     <= HOLDOFF;
               end
            end
            HOLDOFF: begin
               interrupt <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               interrupt <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_capture_5.sv
// Directed bench for int_capture_5: walks the capture latency, ack priority, set-wins,
// level-hold and reset scenarios with hand-computed expectations.
module tb_int_capture_5;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] src;
   logic       mask_wr;
   logic [4:0] mask_data;
   logic       clr_wr;
   logic [4:0] clr_data;
   logic       interrupt_ack;
   logic       interrupt;
   logic [4:0] pending;
   logic [4:0] mask;
   logic [2:0] active_id;

   int n_checks = 0;
   int n_pass   = 0;

   int_capture_5 dut (
      .clk           (clk),
      .reset         (reset),
      .src           (src),
      .mask_wr       (mask_wr),
      .mask_data     (mask_data),
      .clr_wr        (clr_wr),
      .clr_data      (clr_data),
      .interrupt_ack (interrupt_ack),
      .interrupt     (interrupt),
      .pending       (pending),
      .mask          (mask),
      .active_id     (active_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Advance one rising edge; outputs are sampled 1 time unit after it
   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; src = '0; mask_wr = 1'b0; mask_data = '0;
      clr_wr = 1'b0; clr_data = '0; interrupt_ack = 1'b0;
      step(2);
      check("rst_pending", 8'(pending), 8'h00);
      check("rst_mask", 8'(mask), 8'h00);
      check("rst_int", 8'(interrupt), 8'h0);
      check("rst_id", 8'(active_id), 8'h0);
      reset = 1'b0;

      // Basic capture latency on source 2
      mask_wr = 1'b1; mask_data = 5'b00100;
      step();
      mask_wr = 1'b0;
      check("mask_rb", 8'(mask), 8'h04);
      src = 5'b00100;
      step(2);
      check("lat_pend_early", 8'(pending), 8'h00);
      step();
      check("lat_pend", 8'(pending), 8'h04);
      check("lat_int_early", 8'(interrupt), 8'h0);
      step();
      check("lat_int", 8'(interrupt), 8'h1);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("ack2_id", 8'(active_id), 8'h2);
      check("ack2_pend", 8'(pending), 8'h00);
      check("ack2_holdoff", 8'(interrupt), 8'h0);
      step(2);
      check("level_no_reset", 8'(pending), 8'h00);
      check("idle_quiet", 8'(interrupt), 8'h0);

      // Priority on ack: lowest pending index serviced first
      mask_wr = 1'b1; mask_data = 5'b11111;
      step();
      mask_wr = 1'b0;
      src = 5'b01110;
      step(3);
      check("two_pend", 8'(pending), 8'h0A);
      step();
      check("two_int", 8'(interrupt), 8'h1);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("prio_id", 8'(active_id), 8'h1);
      check("prio_pend", 8'(pending), 8'h08);
      check("prio_holdoff", 8'(interrupt), 8'h0);
      step();
      check("prio_idle", 8'(interrupt), 8'h0);
      step();
      check("prio_rereq", 8'(interrupt), 8'h1);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("prio_id3", 8'(active_id), 8'h3);
      check("prio_pend_empty", 8'(pending), 8'h00);
      src = '0;
      step(4);

      // Set wins over a software clear on the same bit
      src = 5'b00001;
      step();
      src = 5'b00000;
      step();
      src = 5'b00001;
      step();
      check("sw_pend0", 8'(pending), 8'h01);
      step();
      check("sw_int", 8'(interrupt), 8'h1);
      clr_wr = 1'b1; clr_data = 5'b00001;
      step();
      check("set_wins", 8'(pending), 8'h01);
      step();
      check("clr_works", 8'(pending), 8'h00);
      check("req_holds", 8'(interrupt), 8'h1);

      // Spurious ack after clearing everything
      clr_data = 5'b11111;
      step();
      clr_wr = 1'b0;
      check("clr_all", 8'(pending), 8'h00);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("spur_id", 8'(active_id), 8'h7);
      check("spur_holdoff", 8'(interrupt), 8'h0);
      step(2);
      check("spur_idle", 8'(interrupt), 8'h0);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("ack_ignored_id", 8'(active_id), 8'h7);
      check("ack_ignored_int", 8'(interrupt), 8'h0);

      // Level held high after clear does not re-set
      src = 5'b01001;
      step(3);
      check("hold_pend", 8'(pending), 8'h08);
      step();
      check("hold_int", 8'(interrupt), 8'h1);
      clr_wr = 1'b1; clr_data = 5'b01000;
      step();
      clr_wr = 1'b0;
      check("hold_clr", 8'(pending), 8'h00);
      step(5);
      check("hold_no_reset", 8'(pending), 8'h00);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("hold_spur_id", 8'(active_id), 8'h7);
      src = 5'b00001;
      step(3);
      src = 5'b01001;
      step(3);
      check("hold_rerise", 8'(pending), 8'h08);

      // Mask change leaves existing pending intact
      mask_wr = 1'b1; mask_data = 5'b00000;
      step();
      mask_wr = 1'b0;
      check("mask_keep_pend", 8'(pending), 8'h08);
      check("mask_zero", 8'(mask), 8'h00);
      check("pre_rst_int", 8'(interrupt), 8'h1);

      // Reset overrides a concurrent ack in REQ
      reset = 1'b1; interrupt_ack = 1'b1;
      step();
      reset = 1'b0; interrupt_ack = 1'b0;
      check("mid_rst_int", 8'(interrupt), 8'h0);
      check("mid_rst_pend", 8'(pending), 8'h00);
      check("mid_rst_mask", 8'(mask), 8'h00);
      check("mid_rst_id", 8'(active_id), 8'h0);
      src = 5'b11001;
      step(4);
      check("post_rst_nocap", 8'(pending), 8'h00);
      check("post_rst_noint", 8'(interrupt), 8'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/int_capture_5.md
INT_CAPTURE_5 -- requirements
Module: int_capture_5

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 src  input  5  asynchronous interrupt source lines; bit i is source i.
REQ-005 mask_wr  input  1  one-cycle strobe that loads mask_data into the enable mask.
REQ-006 mask_data  input  5  new mask value; 1 enables capture for that source.
REQ-007 clr_wr  input  1  one-cycle strobe that clears the pending bits set in clr_data.
REQ-008 clr_data  input  5  write-1-to-clear pattern for pending.
REQ-009 interrupt_ack  input  1  processor acknowledge, one cycle wide.
REQ-010 interrupt  output  1  registered interrupt request to the processor.
REQ-011 pending  output  5  registered pending flags; these feed the downstream 5-input OR (inverted-input NAND) any-pending gate.
REQ-012 mask  output  5  registered current mask, for readback.
REQ-013 active_id  output  3  registered index of the source serviced at the last ack; 7 means spurious.

Function
REQ-014 SHALL pass each src bit through two synchronising flops, s1 then s2, followed by a history flop s3.
REQ-015 SHALL treat rise[i] = s2[i] & ~s3[i] as the event for source i; level-high alone SHALL NOT re-set a cleared bit.
REQ-016 SHALL set pending[i] on the clk edge where rise[i] & mask[i]; mask is sampled before that edge's mask_wr takes effect.
REQ-017 SHALL clear pending[i] when clr_wr & clr_data[i]; when set and clear coincide for one bit, set SHALL win.
REQ-018 A mask change SHALL NOT alter existing pending bits.
REQ-019 Latency: src rises before edge n, so s1=1 after n, s2=1 after n+1, pending=1 after n+2, interrupt=1 after n+3.
REQ-020 SHALL implement an FSM with states IDLE, REQ and HOLDOFF; interrupt=1 only in REQ.
REQ-021 IDLE -> REQ when pending != 0; otherwise stay in IDLE.
REQ-022 REQ: SHALL hold until interrupt_ack=1, even if pending goes to 0 meanwhile; REQ -> HOLDOFF on ack.
REQ-023 On ack in REQ, active_id SHALL get the lowest index i with pending[i]=1, and that bit SHALL auto-clear on the same edge. If no bit is pending, active_id SHALL be 7 and no bit is cleared.
REQ-024 An auto-clear and a new rise on the same bit in the same cycle SHALL leave the bit set, because set wins.
REQ-025 HOLDOFF SHALL last exactly one cycle with interrupt=0, then move to IDLE; remaining pending bits re-request from IDLE on the next edge.
REQ-026 interrupt_ack outside REQ SHALL be ignored.
REQ-027 clr_wr auto-clear and software clear SHALL merge; the effective clear is the OR of both, still overridden by set.

Reset
REQ-028 While reset=1, on each clk edge: s1, s2 and s3 = 0; pending = 0; mask = 0; active_id = 0; interrupt = 0; state = IDLE.
REQ-029 Reset SHALL override all other inputs, including a mid-REQ ack, and SHALL take effect the edge it is sampled.
REQ-030 A src held high through reset MAY produce a rise after reset; it SHALL be captured only if mask was written to 1.

Verification
REQ-031 reset, then mask_wr with mask_data=5'b00100, then src[2] rises -> pending=5'b00100 three edges later; interrupt=1 on the following edge.
REQ-032 pending=5'b01010 in REQ, ack pulse -> active_id=1, pending=5'b01000, one HOLDOFF cycle with interrupt=0, interrupt=1 again one edge after IDLE.
REQ-033 mask=5'b11111, src[0] rises in the same cycle clr_wr=1 with clr_data=5'b00001 and pending[0] already 1 -> pending[0] stays 1.
REQ-034 in REQ, clr_wr with clr_data=5'b11111 clears all, then ack -> active_id=7, interrupt deasserts via HOLDOFF, FSM returns to IDLE and stays.
REQ-035 src[3] held high for 20 cycles with mask[3]=1; clear pending[3] at cycle 10 -> pending[3] does not re-set until src[3] falls and rises again.
REQ-036 reset asserted while interrupt=1 -> next edge interrupt=0, pending=0, mask=0; a subsequent src rise is not captured.
